intr_ctrl: RTL
==============

// Module: intr_ctrl
// PURPOSE
//  Prioritised interrupt controller that drives the CPU's intr input and consumes int_ack/ie.
//  Latches edges from up to N_SRC peripheral sources, masks them, and presents one request at a time.
//  Holds the acknowledged source ID as "in service" until software writes EOI.
//  Programmed over the I/O bus (io_cs/io_rd/io_wr). Its D_Out is OR-combined into the CPU's DY_io return.
// PARAMETERS
//  N_SRC      8      number of interrupt sources, 1..16
//  BASE_ADDR  12'hF00  I/O base address; the block decodes Addr[11:4] == BASE_ADDR[11:4]
// PORTS
//  sys_clk   in   1      system clock; all state changes on the rising edge
//  sys_rst   in   1      asynchronous, active-low reset
//  irq_in    in   N_SRC  raw source lines; asynchronous; a rising edge requests an interrupt
//  ie        in   1      CPU interrupt-enable flag
//  int_ack   in   1      CPU acknowledge, sampled high while intr=1
//  intr      out  1      registered interrupt request to the CPU
//  io_cs     in   1      I/O chip select
//  io_rd     in   1      I/O read strobe
//  io_wr     in   1      I/O write strobe
//  Addr      in   12     I/O byte address
//  D_In      in   32     write data
//  D_Out     out  32     read data; 32'h0 whenever no read of this block is in progress
// BEHAVIOUR
//  Reset (sys_rst=0, async): sync flops=0, PEND=0, MASK=0, VEC=0, state=IDLE, intr=0, D_Out=0.
//  Input path:
//   - 2-flop synchroniser per source, plus a 3rd flop for edge detection.
//   - Rising edge = sync2 & ~sync3.
//   - irq_in first sampled high at edge k -> PEND bit set at edge k+2.
//   - Level-high without a new edge does not re-set PEND.
//  Register map; sel = io_cs & decode hit; word offset = Addr[3:2]:
//   0 PEND  R: {0, PEND}. W: write-1-to-clear.
//   1 MASK  R/W: bit=1 enables the source; upper bits read 0.
//   2 VEC   R: {valid, 26'b0, id[4:0]}. valid=1 only in SERVICE.
//   3 EOI   W: any data ends service. R: 0.
//   - Reads are combinational: D_Out valid in the same cycle as sel & io_rd.
//   - Writes take effect at the clock edge with sel & io_wr. Writes to read-only fields are ignored.
//  Arbitration:
//   - Eligible = PEND & MASK. Winner = lowest-index eligible bit (bit 0 highest priority).
//   - No nesting: only one source is in service at a time.
//  FSM (IDLE, REQ, SERVICE):
//   - IDLE: if ie & |eligible -> REQ; intr=1 from that edge.
//   - REQ, int_ack=1: VEC.id <= current winner; PEND[winner] cleared; intr=0 at the same edge; -> SERVICE.
//   - REQ, ie=0 or eligible==0 (masked or cleared): intr=0; -> IDLE; PEND is kept.
//   - SERVICE: intr held 0. EOI write -> IDLE; VEC.valid cleared.
//     The next request can assert intr one edge later, not at the EOI edge.
//   - int_ack outside REQ is ignored. EOI outside SERVICE is ignored.
//  Simultaneous events:
//   - New edge and W1C on the same bit in the same cycle: set wins.
//   - New edge on the winner's bit in the ack cycle: PEND stays 1 (re-queued).
//   - MASK write in the ack cycle: the winner is computed from pre-edge MASK.
//   - Winner may change while in REQ if PEND/MASK change. The ack captures the winner at the ack edge.
//  Reset mid-operation: reset asserted in any state immediately forces the reset values above.
//   Pending edges are lost.
//  Width rules:
//   - Unused PEND/MASK bits above N_SRC-1 read 0.
//   - id is zero-extended into VEC[4:0].
// TESTING
//  1 Reset: hold sys_rst=0 with irq_in=all-1s -> intr=0, D_Out=0, PEND/MASK/VEC read 0 after release.
//  2 Basic: MASK=8'h04, ie=1, pulse irq_in[2] at edge k -> PEND=8'h04 at k+2, intr=1 at k+3;
//    int_ack -> VEC=32'h8000_0002, PEND=0, intr=0; EOI -> VEC=0.
//  3 Priority: MASK=8'hFF, edges on srcs 5 and 1 in the same cycle -> first ack id=1;
//    after EOI, second ack id=5.
//  4 Gating: pending src 3 with MASK=0 or ie=0 -> intr stays 0.
//    Set MASK[3]=1 with ie=1 -> intr=1 the next edge. Drop ie in REQ -> intr=0, PEND[3] still 1.
//  5 Collisions: W1C PEND[4] in the same cycle as a new edge on src 4 -> PEND[4]=1.
//    Edge on src 0 during SERVICE -> no intr until after EOI.
//  6 Reset mid-SERVICE: assert sys_rst asynchronously between edges -> VEC, PEND, intr=0 immediately.

Source files
------------

// File: rtl/intr_ctrl_if.sv
// ---------------------------------------------------------------------------
// intr_ctrl_if
//   I/O bus seen by the interrupt controller.
//   io_cs / io_rd / io_wr : chip select and read/write strobes
//   Addr                  : 12-bit byte address
//   D_In                  : 32-bit write data
//   D_Out                 : 32-bit read data, OR-combined by the CPU into its
//                           I/O return bus, so it is 0 when not being read
//   master drives the bus (CPU side), slave is the controller.
// ---------------------------------------------------------------------------
interface intr_ctrl_if;
    logic        io_cs;
    logic        io_rd;
    logic        io_wr;
    logic [11:0] Addr;
    logic [31:0] D_In;
    logic [31:0] D_Out;

    modport master (
        output io_cs, io_rd, io_wr, Addr, D_In,
        input  D_Out
    );

    modport slave (
        input  io_cs, io_rd, io_wr, Addr, D_In,
        output D_Out
    );
endinterface

// File: rtl/intr_ctrl.sv
// ---------------------------------------------------------------------------
// intr_ctrl
//   Prioritised interrupt controller. Edge-detects up to N_SRC asynchronous
//   sources into PEND, gates them with MASK, and requests the CPU on intr for
//   the lowest-index eligible source. The acknowledged source is held in
//   service (VEC) until software writes EOI; there is no nesting.
//
//   Ports
//     sys_clk  : system clock, rising edge
//     sys_rst  : asynchronous active-low reset
//     irq_in   : raw source lines, rising edge requests
//     ie       : CPU interrupt-enable flag
//     int_ack  : CPU acknowledge while intr=1
//     intr     : registered request to the CPU
//     io       : I/O bus (slave side)
//
//   Register map (word offset = Addr[3:2], block hit on Addr[11:4]):
//     0 PEND  R / W1C        1 MASK  R/W
//     2 VEC   R {valid,26'b0,id[4:0]}     3 EOI  W (any data)
// ---------------------------------------------------------------------------
module intr_ctrl #(
    parameter int          N_SRC     = 8,
    parameter logic [11:0] BASE_ADDR = 12'hF00
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [N_SRC-1:0] irq_in,
    input  logic             ie,
    input  logic             int_ack,
    output logic             intr,
    intr_ctrl_if.slave       io
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_e;

    state_e             state_q, state_d;
    logic               intr_q, intr_d;
    logic [N_SRC-1:0]   sync1_q, sync1_d;
    logic [N_SRC-1:0]   sync2_q, sync2_d;
    logic [N_SRC-1:0]   sync3_q, sync3_d;
    logic [N_SRC-1:0]   pend_q, pend_d;
    logic [N_SRC-1:0]   mask_q, mask_d;
    logic [4:0]         vec_id_q, vec_id_d;

    logic               sel;
    logic [1:0]         offset;
    logic               wr_pend, wr_mask, wr_eoi;
    logic [N_SRC-1:0]   rise;
    logic [N_SRC-1:0]   eligible;
    logic [N_SRC-1:0]   win_oh;
    logic [4:0]         winner;
    logic               ack_fire;
    logic               unused_bits;

    // Bus decode
    assign sel     = io.io_cs && (io.Addr[11:4] == BASE_ADDR[11:4]);
    assign offset  = io.Addr[3:2];
    assign wr_pend = sel && io.io_wr && (offset == 2'd0);
    assign wr_mask = sel && io.io_wr && (offset == 2'd1);
    assign wr_eoi  = sel && io.io_wr && (offset == 2'd3);

    // Rising edge seen between the 2nd and 3rd synchroniser stages
    assign rise     = sync2_q & ~sync3_q;
    assign eligible = pend_q & mask_q;
    assign ack_fire = (state_q == REQ) && int_ack && (|eligible);

    assign unused_bits = &{1'b0, io.Addr[1:0], io.D_In[31:N_SRC]};

    // Lowest index wins: scan downwards so the last hit is the lowest bit.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        win_oh = '0;
        winner = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_oh    = '0;
                win_oh[i] = 1'b1;
                winner    = 5'(i);
            end
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ie && (|eligible)) state_d = REQ;
            REQ: begin
                if (ack_fire)                      state_d = SERVICE;
                else if (!ie || !(|eligible))      state_d = IDLE;
            end
            SERVICE: if (wr_eoi) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: output (registered next cycle)
    always_comb begin
        intr_d = (state_d == REQ);
    end

    // FSM: state register
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!sys_rst) begin
            state_q <= IDLE;
            intr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            intr_q  <= intr_d;
        end
    end

    // Datapath next-state
    always_comb begin
        sync1_d  = irq_in;
        sync2_d  = sync1_q;
        sync3_d  = sync2_q;
        mask_d   = wr_mask ? io.D_In[N_SRC-1:0] : mask_q;
        vec_id_d = vec_id_q;

        pend_d = pend_q;
        if (wr_pend)  pend_d = pend_d & ~io.D_In[N_SRC-1:0];
        if (ack_fire) pend_d = pend_d & ~win_oh;
        // A new edge is OR-ed in last so it survives a W1C or an ack.
        pend_d = pend_d | rise;

        if (ack_fire)
            vec_id_d = winner;
        else if ((state_q == SERVICE) && wr_eoi)
            vec_id_d = '0;
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            sync3_q  <= '0;
            pend_q   <= '0;
            mask_q   <= '0;
            vec_id_q <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            sync3_q  <= sync3_d;
            pend_q   <= pend_d;
            mask_q   <= mask_d;
            vec_id_q <= vec_id_d;
        end
    end

    // Combinational read; zero when not read so it can be OR-combined.
    always_comb begin
        io.D_Out = 32'h0;
        if (sel && io.io_rd) begin
            case (offset)
                2'd0:    io.D_Out = 32'(pend_q);
                2'd1:    io.D_Out = 32'(mask_q);
                2'd2:    io.D_Out = {(state_q == SERVICE), 26'b0, vec_id_q};
                default: io.D_Out = 32'h0;
            endcase
        end
    end

    assign intr = intr_q;

endmodule
